keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Parametrised matrix-keypad scanner with per-key debounce, ghost-key rejection and a one-deep valid/ready key-event output. It drives the keypad rows, samples the columns, and emits exactly one event per debounced press. It is the next generation of the calculator's row-sweep and column-compare front end and feeds the key-to-display conversion stage. Scan rate, matrix size and debounce depth are set by parameters, so the same block serves the 4x4 keypad and larger layouts.

## Interface
- N_ROWS, 4: number of driven rows (≥2).
- N_COLS, 4: number of sensed columns (≥2).
- SCAN_DIV, 50000: clk cycles per row step (1 kHz step at 50 MHz); must be ≥4.
- DEBOUNCE_SCANS, 8: consecutive full frames a key state must be stable (≥1).
- KEY_W, $clog2(N_ROWS*N_COLS): key code width (derived, not overridden).
- clk, in, 1: system clock; the block's only clock.
- rst, in, 1: reset, synchronous and active-high.
- col, in, N_COLS: raw column inputs, active-high, asynchronous to clk.
- fil, out, N_ROWS: one-hot active-high row drive.
- key_code, out, KEY_W: row*N_COLS + column of the accepted key.
- key_op, out, 1: high when the key lies in column N_COLS-1 (operator column).
- key_valid, out, 1: event available.
- key_ready, in, 1: consumer accepts the event.
- overrun, out, 1: sticky; an event was dropped because the buffer was full.

## Operation
- Two-flop synchroniser on col; all logic uses the synchronised value.
- Tick counter runs 0..SCAN_DIV-1. A tick occurs when the count equals SCAN_DIV-1. On a tick the synchronised col is sampled for the current row, then the row index advances and wraps from N_ROWS-1 to 0.
- A frame is N_ROWS ticks. The frame-end tick is the tick with row index N_ROWS-1.
- Frame accumulation tracks the pressed-key count (saturating at 2) and the first pressed key, lowest row first, then lowest column. A count of 2 is a multi-key frame.
- Frame classes at frame end: NONE (0 keys), SINGLE(k) (exactly 1 key), MULTI (2 or more keys).
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. A stable counter saturates at DEBOUNCE_SCANS.
  - IDLE: SINGLE(k) sets cand=k and stab=1. If DEBOUNCE_SCANS=1, accept immediately; otherwise go to PRESS_DB. NONE and MULTI stay in IDLE.
  - PRESS_DB: SINGLE(cand) increments stab, and reaching DEBOUNCE_SCANS accepts. SINGLE of a different key sets cand to the new key with stab=1. NONE or MULTI returns to IDLE.
  - Accept: emit an event for cand and go to HELD.
  - HELD: NONE sets stab=1 and goes to RELEASE_DB, or straight to IDLE when DEBOUNCE_SCANS=1. SINGLE and MULTI stay in HELD (no auto-repeat, no second key).
  - RELEASE_DB: NONE increments stab, and reaching DEBOUNCE_SCANS goes to IDLE. Any key returns to HELD.
- Output buffer:
  - An event with key_valid=0 loads key_code and key_op and sets key_valid.
  - key_valid and key_ready high together clears key_valid.
  - An event while key_valid=1 and key_ready=0 is dropped; the old code is kept and overrun is set.
  - Same-cycle event and handshake: the new event loads and key_valid stays 1.
- overrun clears only on rst.

## Timing
- Reset values: fil = one-hot row 0; key_valid=0, key_code=0, key_op=0, overrun=0. FSM is IDLE, tick counter and row index are 0, synchroniser flops are 0, frame accumulator is cleared.
- Row p is driven for exactly SCAN_DIV cycles. Its sample is taken at the last cycle, which leaves at least 2 cycles of synchroniser settle.
- Press latency: key_valid rises 1 cycle after the frame-end tick of the DEBOUNCE_SCANS-th consecutive SINGLE(k) frame.
- Outputs are registered; there is no combinational path from key_ready to key_valid.
- rst mid-frame or mid-debounce discards the partial frame and the candidate. No event is emitted.

## Structure
- A shared package holds the FSM state enum (IDLE, PRESS_DB, HELD, RELEASE_DB), the frame class encoding and a key-code width function.
- One natural sub-module, keypad_frame_acc: row-sample accumulation and first-key/count logic, producing the frame class and key at frame end.
- Tick divider, FSM and output buffer stay in keypad_scan_ctrl.

## Test plan
Parameters for all cases: N_ROWS=4, N_COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3 (frame = 16 cycles).
- Reset release: fil=0001, then 0010 after 4 cycles, wrapping to 0001 after 16 cycles. key_valid=0 and overrun=0 throughout.
- Hold row 2 / column 1 for 6 frames: exactly one event, key_code=9, key_op=0, key_valid rising 1 cycle after the 3rd qualifying frame end. Then release for 3 frames and press row 0 / column 3: key_code=3, key_op=1.
- Bounce pattern present, absent, present, present, present (one frame each): no event until the last of the three consecutive present frames.
- Simultaneous row 1 / column 0 and row 3 / column 2 for 5 frames: no event. Release one key: the remaining key is accepted after 3 frames.
- key_ready held 0 across two separate debounced presses (codes 5 then 10): key_code stays 5 and overrun=1. Pulsing key_ready clears key_valid while overrun stays 1.
- rst pulsed during the 2nd frame of a debounce: no event. After rst the key must be stable for a full 3 frames again.

Source files
------------

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types for the keypad scanner: debounce FSM states, frame
// classification and key-code width helper.
package keypad_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_SINGLE = 2'd1,
    FC_MULTI  = 2'd2
  } frame_cls_e;

  // Width of a key code able to address n_keys keys (at least 1 bit).
  function automatic int key_width(input int n_keys);
    return (n_keys <= 2) ? 1 : $clog2(n_keys);
  endfunction

endpackage

// File: rtl/keypad_frame_acc.sv
// Per-frame accumulation of row samples: tracks how many keys were seen
// (saturating at 2) and the first pressed key in row-major order. The
// frame result is presented combinationally on the frame-end tick so it
// already includes the last row's sample.
module keypad_frame_acc
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int KEY_W  = key_width(N_ROWS * N_COLS),
  parameter int ROW_W  = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sample,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [N_COLS-1:0] i_col,
  output logic              o_frame_end,
  output frame_cls_e        o_cls,
  output logic [KEY_W-1:0]  o_key,
  output logic              o_key_op
);

  localparam int COL_W = $clog2(N_COLS);

  logic [1:0]       r_cnt;
  logic [KEY_W-1:0] r_key;
  logic             r_op;

  logic [1:0]       w_row_cnt;
  logic [COL_W-1:0] w_first_col;
  logic [KEY_W-1:0] w_row_key;
  logic             w_row_op;
  logic [2:0]       w_sum;
  logic [1:0]       w_cnt;
  logic [KEY_W-1:0] w_key;
  logic             w_op;

  // Count pressed columns in this row and find the lowest one.
  always_comb begin
    w_row_cnt   = 2'd0;
    w_first_col = '0;
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (i_col[c]) begin
        if (w_row_cnt == 2'd0) w_first_col = COL_W'(c);
        if (w_row_cnt != 2'd2) w_row_cnt = w_row_cnt + 2'd1;
      end
    end
    w_row_key = KEY_W'(int'(i_row) * N_COLS + int'(w_first_col));
    w_row_op  = (w_first_col == COL_W'(N_COLS - 1));
  end

  // Merge this row into the running frame state; earlier rows win the first-key slot.
  always_comb begin
    w_key = r_key;
    w_op  = r_op;
    if ((r_cnt == 2'd0) && (w_row_cnt != 2'd0)) begin
      w_key = w_row_key;
      w_op  = w_row_op;
    end
    w_sum = {1'b0, r_cnt} + {1'b0, w_row_cnt};
    w_cnt = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

    o_frame_end = i_sample && (i_row == ROW_W'(N_ROWS - 1));
    o_key       = w_key;
    o_key_op    = w_op;
    case (w_cnt)
      2'd0:    o_cls = FC_NONE;
      2'd1:    o_cls = FC_SINGLE;
      default: o_cls = FC_MULTI;
    endcase
  end

  // Hold the accumulation between ticks; start fresh after each frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_key <= '0;
      r_op  <= 1'b0;
    end else if (i_sample) begin
      if (o_frame_end) begin
        r_cnt <= '0;
        r_key <= '0;
        r_op  <= 1'b0;
      end else begin
        r_cnt <= w_cnt;
        r_key <= w_key;
        r_op  <= w_op;
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: row sweep, column synchroniser, frame-level
// debounce with ghost-key rejection and a one-deep key event buffer.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int  N_ROWS         = 4,
  parameter int  N_COLS         = 4,
  parameter int  SCAN_DIV       = 50000,
  parameter int  DEBOUNCE_SCANS = 8,
  localparam int KEY_W          = key_width(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_COLS-1:0] col,
  output logic [N_ROWS-1:0] fil,
  output logic [KEY_W-1:0]  key_code,
  output logic              key_op,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              overrun
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int ROW_W  = $clog2(N_ROWS);
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STAB_W-1:0] DB_MAX = STAB_W'(DEBOUNCE_SCANS);

  logic [N_COLS-1:0] r_col_s1, r_col_s2;
  logic [TICK_W-1:0] r_tick;
  logic [ROW_W-1:0]  r_row;
  logic [N_ROWS-1:0] r_fil;
  scan_state_e       r_state;
  logic [KEY_W-1:0]  r_cand;
  logic              r_cand_op;
  logic [STAB_W-1:0] r_stab;
  logic              r_valid;
  logic [KEY_W-1:0]  r_code;
  logic              r_op;
  logic              r_ovr;

  logic              w_tick;
  logic              w_frame_end;
  frame_cls_e        w_cls;
  logic [KEY_W-1:0]  w_key;
  logic              w_key_op;
  scan_state_e       w_state_nx;
  logic [KEY_W-1:0]  w_cand_nx;
  logic              w_cand_op_nx;
  logic [STAB_W-1:0] w_stab_nx;
  logic [STAB_W-1:0] w_stab_inc;
  logic              w_event;

  assign w_tick    = (r_tick == TICK_W'(SCAN_DIV - 1));
  assign fil       = r_fil;
  assign key_code  = r_code;
  assign key_op    = r_op;
  assign key_valid = r_valid;
  assign overrun   = r_ovr;

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else begin
      r_col_s1 <= col;
      r_col_s2 <= r_col_s1;
    end
  end

  // Tick divider and row sweep; fil is kept as a one-hot copy of the row index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
      r_row  <= '0;
      r_fil  <= N_ROWS'(1);
    end else if (w_tick) begin
      r_tick <= '0;
      if (r_row == ROW_W'(N_ROWS - 1)) begin
        r_row <= '0;
        r_fil <= N_ROWS'(1);
      end else begin
        r_row <= r_row + 1'b1;
        r_fil <= r_fil << 1;
      end
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  keypad_frame_acc #(
    .N_ROWS (N_ROWS),
    .N_COLS (N_COLS),
    .KEY_W  (KEY_W),
    .ROW_W  (ROW_W)
  ) u_frame_acc (
    .clk         (clk),
    .rst         (rst),
    .i_sample    (w_tick),
    .i_row       (r_row),
    .i_col       (r_col_s2),
    .o_frame_end (w_frame_end),
    .o_cls       (w_cls),
    .o_key       (w_key),
    .o_key_op    (w_key_op)
  );

  // Debounce FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_cand_op <= 1'b0;
      r_stab    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cand    <= w_cand_nx;
      r_cand_op <= w_cand_op_nx;
      r_stab    <= w_stab_nx;
    end
  end

  // Debounce next-state logic, evaluated once per frame; w_event marks an accepted press.
  always_comb begin
    w_state_nx   = r_state;
    w_cand_nx    = r_cand;
    w_cand_op_nx = r_cand_op;
    w_stab_nx    = r_stab;
    w_event      = 1'b0;
    w_stab_inc   = (r_stab == DB_MAX) ? r_stab : r_stab + 1'b1;
    if (w_frame_end) begin
      case (r_state)
        IDLE: begin
          if (w_cls == FC_SINGLE) begin
            w_cand_nx    = w_key;
            w_cand_op_nx = w_key_op;
            w_stab_nx    = STAB_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_event    = 1'b1;
              w_state_nx = HELD;
            end else begin
              w_state_nx = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if ((w_cls == FC_SINGLE) && (w_key == r_cand)) begin
            w_stab_nx = w_stab_inc;
            if (w_stab_inc == DB_MAX) begin
              w_event    = 1'b1;
              w_state_nx = HELD;
            end
          end else if (w_cls == FC_SINGLE) begin
            w_cand_nx    = w_key;
            w_cand_op_nx = w_key_op;
            w_stab_nx    = STAB_W'(1);
          end else begin
            w_state_nx = IDLE;
          end
        end
        HELD: begin
          if (w_cls == FC_NONE) begin
            w_stab_nx  = STAB_W'(1);
            w_state_nx = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (w_cls == FC_NONE) begin
            w_stab_nx = w_stab_inc;
            if (w_stab_inc == DB_MAX) w_state_nx = IDLE;
          end else begin
            w_state_nx = HELD;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // One-deep event buffer: a same-cycle handshake frees the slot for the new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_op    <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_event) begin
      if (!r_valid || key_ready) begin
        r_valid <= 1'b1;
        r_code  <= w_cand_nx;
        r_op    <= w_cand_op_nx;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && key_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule
